// File: rtl/mmio_arb_pkg.sv
// Shared types and the round-robin pick used by the MMIO bus arbiter.
package mmio_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef logic master_id_t;
  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  typedef struct packed {
    logic       valid;
    master_id_t id;
  } grant_t;

  // While locked only the owner is eligible; otherwise a tie goes to the master not granted last.
  function automatic grant_t rr_pick(input logic [1:0] req, input master_id_t last,
                                     input logic lock, input master_id_t owner);
    grant_t g;
    g.valid = 1'b0;
    g.id    = M0;
    if (lock) begin
      g.valid = req[owner];
      g.id    = owner;
    end else begin
      case (req)
        2'b01:   begin g.valid = 1'b1; g.id = M0;    end
        2'b10:   begin g.valid = 1'b1; g.id = M1;    end
        2'b11:   begin g.valid = 1'b1; g.id = ~last; end
        default: begin g.valid = 1'b0; g.id = M0;    end
      endcase
    end
    return g;
  endfunction

endpackage

// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter onto the single MMIO bus: round-robin with an optional owner lock
// that is released by an unlocked access or after LOCK_TO idle cycles.
//
//  state | meaning
//  IDLE  | pick a winner among eligible requests, latch its command
//  ISSUE | one-cycle bus strobe, read data captured at the closing edge
//  RESP  | one-cycle ack to the owner, lock state updated
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int AW      = 21,
  parameter int DW      = 32,
  parameter int LOCK_TO = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wr_data,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rd_data,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wr_data,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rd_data,
  output logic          mmio_cs,
  output logic          mmio_wr,
  output logic          mmio_rd,
  output logic [AW-1:0] mmio_addr,
  output logic [DW-1:0] mmio_wr_data,
  input  logic [DW-1:0] mmio_rd_data,
  output logic          owner,
  output logic          locked
);

  localparam int CW = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;

  state_t        state;
  master_id_t    last;
  logic          lat_lock;
  logic [DW-1:0] rd_q;
  logic [CW-1:0] lock_cnt;

  logic [1:0]    req;
  grant_t        grant;
  logic          win_wr;
  logic          win_lock;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wr_data;

  assign req         = {m1_req, m0_req};
  assign grant       = rr_pick(req, last, locked, owner);
  assign win_wr      = grant.id ? m1_wr      : m0_wr;
  assign win_lock    = grant.id ? m1_lock    : m0_lock;
  assign win_addr    = grant.id ? m1_addr    : m0_addr;
  assign win_wr_data = grant.id ? m1_wr_data : m0_wr_data;

  assign m0_rd_data = rd_q;
  assign m1_rd_data = rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last         <= M1;
      owner        <= M0;
      locked       <= 1'b0;
      lat_lock     <= 1'b0;
      lock_cnt     <= '0;
      rd_q         <= '0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant.valid) begin
            state        <= ISSUE;
            owner        <= grant.id;
            last         <= grant.id;
            lat_lock     <= win_lock;
            lock_cnt     <= '0;
            mmio_cs      <= 1'b1;
            mmio_wr      <= win_wr;
            mmio_rd      <= ~win_wr;
            mmio_addr    <= win_addr;
            mmio_wr_data <= win_wr_data;
          end else if (locked) begin
            // No grant while locked means the owner is idle: run the release timer.
            if (lock_cnt == CW'(LOCK_TO - 1)) begin
              locked   <= 1'b0;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= lock_cnt + CW'(1);
            end
          end
        end
        ISSUE: begin
          if (mmio_rd) rd_q <= mmio_rd_data;
          mmio_cs      <= 1'b0;
          mmio_wr      <= 1'b0;
          mmio_rd      <= 1'b0;
          mmio_addr    <= '0;
          mmio_wr_data <= '0;
          m0_ack       <= (owner == M0);
          m1_ack       <= (owner == M1);
          state        <= RESP;
        end
        RESP: begin
          m0_ack   <= 1'b0;
          m1_ack   <= 1'b0;
          locked   <= lat_lock;
          lock_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter: single access, round-robin, read capture, lock,
// lock timeout and reset during an access.
module tb_mmio_bus_arbiter;

  localparam int AW = 21;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_lock, m0_wr;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wr_data;
  logic          m0_ack;
  logic [DW-1:0] m0_rd_data;
  logic          m1_req, m1_lock, m1_wr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wr_data;
  logic          m1_ack;
  logic [DW-1:0] m1_rd_data;
  logic          mmio_cs, mmio_wr, mmio_rd;
  logic [AW-1:0] mmio_addr;
  logic [DW-1:0] mmio_wr_data;
  logic [DW-1:0] slot_data;
  logic          owner, locked;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mmio_bus_arbiter #(.AW(AW), .DW(DW), .LOCK_TO(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_wr(m0_wr), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_wr(m1_wr), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr),
    .mmio_wr_data(mmio_wr_data), .mmio_rd_data(slot_data),
    .owner(owner), .locked(locked)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle where the expected winner is already requesting.
  task automatic access(input logic own, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic chk_rd, input logic [DW-1:0] rd_exp);
    cyc();
    chk("issue_owner", owner, own);
    chk("issue_cs", mmio_cs, 1);
    chk("issue_wr", mmio_wr, wr);
    chk("issue_rd", mmio_rd, !wr);
    chk("issue_addr", mmio_addr, addr);
    if (wr) chk("issue_wdata", mmio_wr_data, wdata);
    chk("issue_noack", {m1_ack, m0_ack}, 2'b00);
    cyc();
    chk("resp_cs", {mmio_cs, mmio_wr, mmio_rd}, 3'b000);
    chk("resp_ack", {m1_ack, m0_ack}, own ? 2'b10 : 2'b01);
    if (chk_rd) chk("resp_rd_data", own ? m1_rd_data : m0_rd_data, rd_exp);
    cyc();
    chk("idle_ack", {m1_ack, m0_ack}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_lock = 0; m0_wr = 0; m0_addr = '0; m0_wr_data = '0;
    m1_req = 0; m1_lock = 0; m1_wr = 0; m1_addr = '0; m1_wr_data = '0;
    slot_data = '0;
    cyc(); cyc();
    chk("rst_strobes", {mmio_cs, mmio_wr, mmio_rd}, 3'b000);
    chk("rst_acks", {m1_ack, m0_ack}, 2'b00);
    chk("rst_owner_locked", {owner, locked}, 2'b00);
    chk("rst_addr", mmio_addr, 0);
    chk("rst_rd_data", m0_rd_data, 0);
    reset = 1'b0;
    cyc();

    // Lone M0 write
    m0_req = 1; m0_wr = 1; m0_addr = 21'h00080; m0_wr_data = 32'h2A;
    access(1'b0, 1'b1, 21'h00080, 32'h2A, 1'b0, '0);
    m0_req = 0;

    // Fresh reset, then both masters reading continuously: strict alternation from M0
    reset = 1'b1; cyc(); reset = 1'b0;
    m0_wr = 0; m0_addr = 21'h00010; m1_wr = 0; m1_addr = 21'h00020;
    slot_data = 32'h1111_1111;
    m0_req = 1; m1_req = 1;
    access(1'b0, 1'b0, 21'h00010, '0, 1'b1, 32'h1111_1111);
    access(1'b1, 1'b0, 21'h00020, '0, 1'b1, 32'h1111_1111);
    access(1'b0, 1'b0, 21'h00010, '0, 1'b1, 32'h1111_1111);
    access(1'b1, 1'b0, 21'h00020, '0, 1'b1, 32'h1111_1111);
    m0_req = 0; m1_req = 0;

    // Lone M1 read; captured data held after the slot changes
    m1_req = 1; m1_addr = 21'h00044; slot_data = 32'hDEAD_BEEF;
    access(1'b1, 1'b0, 21'h00044, '0, 1'b1, 32'hDEAD_BEEF);
    m1_req = 0; slot_data = 32'h0;
    cyc(); cyc();
    chk("rd_hold_m1", m1_rd_data, 32'hDEAD_BEEF);
    chk("rd_hold_m0", m0_rd_data, 32'hDEAD_BEEF);

    // M1 holds a lock for three writes while M0 waits; unlocked fourth write hands over
    m1_req = 1; m1_lock = 1; m1_wr = 1; m1_addr = 21'h00100; m1_wr_data = 32'h1;
    access(1'b1, 1'b1, 21'h00100, 32'h1, 1'b0, '0);
    chk("lock_set", locked, 1);
    m0_req = 1; m0_wr = 0; m0_addr = 21'h00200;
    m1_wr_data = 32'h2;
    access(1'b1, 1'b1, 21'h00100, 32'h2, 1'b0, '0);
    m1_wr_data = 32'h3;
    access(1'b1, 1'b1, 21'h00100, 32'h3, 1'b0, '0);
    chk("lock_held", locked, 1);
    m1_lock = 0; m1_wr_data = 32'h4;
    access(1'b1, 1'b1, 21'h00100, 32'h4, 1'b0, '0);
    chk("lock_released", locked, 0);
    chk("wr_keeps_rd", m0_rd_data, 32'hDEAD_BEEF);
    slot_data = 32'h0BAD_F00D;
    access(1'b0, 1'b0, 21'h00200, '0, 1'b1, 32'h0BAD_F00D);
    m0_req = 0; m1_req = 0;

    // Lock timeout: M1 locks then goes quiet; M0 gets the bus after 8 idle cycles
    m1_req = 1; m1_lock = 1; m1_wr = 0; m1_addr = 21'h00300; slot_data = 32'h1234_5678;
    access(1'b1, 1'b0, 21'h00300, '0, 1'b1, 32'h1234_5678);
    chk("to_locked", locked, 1);
    m1_req = 0; m1_lock = 0; m0_req = 1;
    repeat (7) cyc();
    chk("to_still_locked", locked, 1);
    chk("to_m0_waits", {mmio_cs, m0_ack}, 2'b00);
    cyc();
    chk("to_expired", locked, 0);
    chk("to_no_grant_yet", mmio_cs, 0);
    access(1'b0, 1'b0, 21'h00200, '0, 1'b1, 32'h1234_5678);

    // Reset during ISSUE of an M1 access
    m1_req = 1;
    cyc();
    chk("rstmid_owner", owner, 1);
    chk("rstmid_cs", mmio_cs, 1);
    reset = 1'b1;
    cyc();
    chk("rstmid_strobes", {mmio_cs, mmio_wr, mmio_rd}, 3'b000);
    chk("rstmid_noack", {m1_ack, m0_ack}, 2'b00);
    chk("rstmid_owner_locked", {owner, locked}, 2'b00);
    cyc();
    chk("rstmid_noack2", {m1_ack, m0_ack}, 2'b00);
    reset = 1'b0;
    access(1'b0, 1'b0, 21'h00200, '0, 1'b0, '0);
    m0_req = 0; m1_req = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
